// File: rtl/pipelined_adder_nbit_if.sv
// Operand/result bundle for pipelined_adder_nbit. Build option for the adder: PIPE_ADDER_OVF_EN.
// Handshake: a transfer happens on a rising edge where valid && ready; valid and the payload stay stable until the transfer.
interface pipelined_adder_nbit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder_nbit.sv
// Pipelined add/subtract: WIDTH bits resolved SEG_W bits per clock with the carry registered between stages.
// Define PIPE_ADDER_OVF_EN to compute and register signed overflow; otherwise ovf is tied to 0.
module pipelined_adder_nbit #(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_adder_nbit_if.slave bus
);
    localparam int STAGES = WIDTH / SEG_W;

    logic adv;
    logic out_valid;

    // Entry values of each stage: index 0 comes from the ports, index k>0 from stage k-1 registers.
    logic [WIDTH-1:0] ent_a   [STAGES];
    logic [WIDTH-1:0] ent_b   [STAGES];
    logic [WIDTH-1:0] ent_sum [STAGES];
    logic             ent_c   [STAGES];
    logic             ent_v   [STAGES];

    assign adv           = !out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;

    assign ent_a[0]   = bus.a;
    assign ent_b[0]   = bus.sub ? ~bus.b : bus.b;
    assign ent_c[0]   = bus.sub ? 1'b1 : bus.cin;
    assign ent_v[0]   = bus.in_valid;
    assign ent_sum[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG_W:0]   seg_sum;
        logic [WIDTH-1:0] sum_d;
        logic [WIDTH-1:0] sum_q;
        logic             carry_q;
        logic             valid_q;

        assign seg_sum = {1'b0, ent_a[k][k*SEG_W +: SEG_W]}
                       + {1'b0, ent_b[k][k*SEG_W +: SEG_W]}
                       + {{SEG_W{1'b0}}, ent_c[k]};

        always_comb begin
            sum_d = ent_sum[k];
            sum_d[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= ent_v[k];
                carry_q <= seg_sum[SEG_W];
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] opa_q;
            logic [WIDTH-1:0] opb_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa_q <= '0;
                    opb_q <= '0;
                end else if (adv) begin
                    opa_q <= ent_a[k];
                    opb_q <= ent_b[k];
                end
            end

            assign ent_a[k+1]   = opa_q;
            assign ent_b[k+1]   = opb_q;
            assign ent_c[k+1]   = carry_q;
            assign ent_v[k+1]   = valid_q;
            assign ent_sum[k+1] = sum_q;
        end else begin : g_last
            assign out_valid = valid_q;
            assign bus.s     = sum_q;
            assign bus.cout  = carry_q;
`ifdef PIPE_ADDER_OVF_EN
            logic msb_cin;
            logic ovf_q;

            // Carry into the MSB recovered from its sum bit and its two operand bits.
            assign msb_cin = sum_d[WIDTH-1] ^ ent_a[k][WIDTH-1] ^ ent_b[k][WIDTH-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= msb_cin ^ seg_sum[SEG_W];
                end
            end

            assign bus.ovf = ovf_q;
`else
            assign bus.ovf = 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Self-checking bench: 4-stage 64-bit adder and 1-stage 32-bit adder, scoreboard driven by a reference model.
module tb_pipelined_adder_nbit;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_nbit_if #(.WIDTH(64)) bus0 ();
    pipelined_adder_nbit_if #(.WIDTH(32)) bus1 ();

    pipelined_adder_nbit #(.WIDTH(64), .SEG_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pipelined_adder_nbit #(.WIDTH(32), .SEG_W(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    bit lat_chk  = 1'b1;
    int lat0, lat1;
    int n_out0 = 0;
    int base_out;

    logic [65:0] exp0_q[$];
    logic [65:0] exp1_q[$];
    int          t0_q[$];
    int          t1_q[$];

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference result packed as {ovf, cout, s} for a w-bit adder.
    function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
        logic [63:0] mask, bb;
        logic [64:0] full;
        logic        c, ovf;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        bb   = (sub ? ~b : b) & mask;
        full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sub ? 1'b1 : cin)};
        c    = full[w];
        ovf  = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
`ifndef PIPE_ADDER_OVF_EN
        ovf  = 1'b0;
`endif
        return {ovf, c, full[63:0] & mask};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus0.out_valid && bus0.out_ready) begin
                if (exp0_q.size() == 0) check("spurious0", 66'(1), 66'(0));
                else begin
                    check("result0", {bus0.ovf, bus0.cout, bus0.s}, exp0_q.pop_front());
                    lat0 = cyc - t0_q.pop_front();
                    if (lat_chk) check("latency0", 66'(lat0), 66'(4));
                    n_out0++;
                end
            end
            if (bus0.in_valid && bus0.in_ready) begin
                exp0_q.push_back(model(64, bus0.a, bus0.b, bus0.cin, bus0.sub));
                t0_q.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (exp1_q.size() == 0) check("spurious1", 66'(1), 66'(0));
                else begin
                    check("result1", {bus1.ovf, bus1.cout, 32'h0, bus1.s}, exp1_q.pop_front());
                    lat1 = cyc - t1_q.pop_front();
                    if (lat_chk) check("latency1", 66'(lat1), 66'(1));
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                exp1_q.push_back(model(32, 64'(bus1.a), 64'(bus1.b), bus1.cin, bus1.sub));
                t1_q.push_back(cyc);
            end
        end
    end

    task automatic send0(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bit ok = 1'b0;
        bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub; bus0.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus0.in_ready;
            @(posedge clk);
            #1;
        end
        bus0.in_valid = 1'b0;
        check("send0_accepted", 66'(ok), 66'(1));
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bit ok = 1'b0;
        bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub; bus1.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus1.in_ready;
            @(posedge clk);
            #1;
        end
        bus1.in_valid = 1'b0;
        check("send1_accepted", 66'(ok), 66'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp0_q.size() != 0 || exp1_q.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        check("drain0_empty", 66'(exp0_q.size()), 66'(0));
        check("drain1_empty", 66'(exp1_q.size()), 66'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp0_q.delete(); t0_q.delete();
        exp1_q.delete(); t1_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 66'(bus0.out_valid), 66'(0));
        check("rst_s", 66'(bus0.s), 66'(0));
        check("rst_cout", 66'(bus0.cout), 66'(0));
        check("rst_ovf", 66'(bus0.ovf), 66'(0));
        check("rst_in_ready", 66'(bus0.in_ready), 66'(1));
        check("rst_out_valid1", 66'(bus1.out_valid), 66'(0));
        @(posedge clk);
        #1;

        // Directed corner cases
        send0(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send0(64'd5, 64'd7, 1'b0, 1'b1);
        send0(64'd7, 64'd5, 1'b1, 1'b1);
        send0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        send0(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        send0(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0);
        drain();

        // Streaming i+i
        base_out = n_out0;
        for (int i = 1; i <= 8; i++) send0(64'(i), 64'(i), 1'b0, 1'b0);
        drain();
        check("stream_count", 66'(n_out0 - base_out), 66'(8));

        // Back-pressure
        lat_chk = 1'b0;
        bus0.out_ready = 1'b0;
        send0(64'd100, 64'd23, 1'b0, 1'b0);
        send0(64'd200, 64'd50, 1'b0, 1'b1);
        send0(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 20 && !bus0.out_valid; i++) @(negedge clk);
        check("bp_out_valid", 66'(bus0.out_valid), 66'(1));
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_s", 66'(bus0.s), 66'(exp0_q[0][63:0]));
            check("bp_in_ready", 66'(bus0.in_ready), 66'(0));
            check("bp_hold_valid", 66'(bus0.out_valid), 66'(1));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b1;
        send0(64'd1, 64'd2, 1'b0, 1'b0);
        send0(64'd9, 64'd4, 1'b0, 1'b1);
        drain();

        // Random traffic with random back-pressure
        fork
            begin
                repeat (80) begin
                    @(posedge clk);
                    #1;
                    bus0.out_ready = 1'($urandom_range(0, 1));
                end
                bus0.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 30; i++)
                    send0({$urandom, $urandom}, {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        join
        bus0.out_ready = 1'b1;
        drain();
        lat_chk = 1'b1;

        // Reset with two operands in flight
        send0(64'd11, 64'd22, 1'b0, 1'b0);
        send0(64'd33, 64'd44, 1'b0, 1'b0);
        pulse_reset();
        @(negedge clk);
        check("rst_mid_in_ready", 66'(bus0.in_ready), 66'(1));
        for (int i = 0; i < 8; i++) begin
            check("rst_mid_out_valid", 66'(bus0.out_valid), 66'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #1;

        // Single-stage adder
        send1(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        send1(32'd5, 32'd7, 1'b0, 1'b1);
        send1(32'd7, 32'd5, 1'b0, 1'b1);
        send1(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            send1($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        bus1.out_ready = 1'b0;
        send1(32'd3, 32'd4, 1'b0, 1'b0);
        pulse_reset();
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst1_out_valid", 66'(bus1.out_valid), 66'(0));
        end
        @(posedge clk);
        #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
